// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the program-counter generator: default geometry,
// reset/trap vectors and the FSM state encoding.
// Imported by pc_gen_unit; pc_add_n is fully width-generic and needs none of it.
package pc_gen_unit_pkg;

  // Default PC geometry: 16-bit addresses, 16-bit instructions.
  localparam int PC_XLEN       = 16;
  localparam int PC_INC        = 2;
  localparam int PC_ALIGN_BITS = 1;

  // Default vectors, sized for the default width; the top resizes them.
  localparam logic [PC_XLEN-1:0] PC_RESET_VEC = 16'h0000;
  localparam logic [PC_XLEN-1:0] PC_TRAP_VEC  = 16'h0004;

  // Control state of the PC unit.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,  // first cycle after reset release, no fetch yet
    ST_RUN  = 2'd1,  // normal fetching
    ST_TRAP = 2'd2   // misaligned redirect captured, waiting for trap_clr
  } pc_state_e;

endpackage

// File: rtl/pc_gen_unit_add_n.sv
// Purpose: W-bit combinational ripple-carry adder (a + b + cin), carry-out dropped.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no flow control.
module pc_add_n #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  // carry[i] is the carry into bit i; the carry out of the MSB is never built,
  // which gives modulo-2^W arithmetic for free.
  logic [W-1:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    // One full adder per bit.
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Purpose: PC register with sequential increment, relative/absolute redirect and alignment trap.
// Latency: one cycle from an accepted fetch or redirect to the new pc_out.
// Backpressure: pc_out holds while fetch_valid & !fetch_ready or stall; a redirect overrides both.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int              XLEN       = PC_XLEN,
  parameter int              INC        = PC_INC,
  parameter int              ALIGN_BITS = PC_ALIGN_BITS,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(PC_TRAP_VEC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic            redirect_abs,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_off,
  input  logic            fetch_ready,
  input  logic            trap_clr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            fetch_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] trap_addr
);

  // Low target bits that must be clear; ALIGN_BITS = 0 yields an all-zero mask,
  // which disables the check without a separate code path.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] INC_VAL    = XLEN'(INC);

  pc_state_e       state_q;
  pc_state_e       state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] trap_addr_q;
  logic [XLEN-1:0] trap_addr_d;
  logic            fetch_valid_q;
  logic            misalign_err_q;

  logic [XLEN-1:0] target_base;
  logic [XLEN-1:0] target;
  logic            target_misaligned;
  logic            fetch_accept;

  // Sequential link value: pc_out + INC.
  pc_add_n #(
    .W(XLEN)
  ) u_inc_add (
    .a  (pc_q),
    .b  (INC_VAL),
    .cin(1'b0),
    .sum(pc_plus_inc)
  );

  // Redirect target: PC-relative or base-relative (JALR-style).
  assign target_base = redirect_abs ? redirect_base : pc_q;

  pc_add_n #(
    .W(XLEN)
  ) u_target_add (
    .a  (target_base),
    .b  (redirect_off),
    .cin(1'b0),
    .sum(target)
  );

  assign target_misaligned = |(target & ALIGN_MASK);
  assign fetch_accept      = fetch_valid_q & fetch_ready & ~stall;

  // Next-state and next-PC selection; redirect beats stall and the handshake.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          if (target_misaligned) begin
            trap_addr_d = target;
            state_d     = ST_TRAP;
          end else begin
            pc_d = target;
          end
        end else if (fetch_accept) begin
          pc_d = pc_plus_inc;
        end
      end
      ST_TRAP: begin
        if (trap_clr) begin
          pc_d    = TRAP_VEC;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, PC and registered status outputs; reset aborts anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_VEC;
      trap_addr_q    <= '0;
      fetch_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      trap_addr_q    <= trap_addr_d;
      fetch_valid_q  <= (state_d == ST_RUN);
      misalign_err_q <= (state_d == ST_TRAP);
    end
  end

  assign pc_out       = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign misalign_err = misalign_err_q;
  assign trap_addr    = trap_addr_q;

endmodule
